i2c_slave_target: RTL and testbench
===================================

Name: i2c_slave_target

Overview:
Synthesizable I2C slave endpoint that sits on the same SCL/SDA bus the master BFM drives. It is the downstream consumer of the master's bit stream and the RTL DUT for the AVIP.
- Decodes START, 7-bit address, R/W bit, register pointer, data bytes and STOP.
- Owns a small register file and drives SDA open-drain for ACK and read data.
- Bits travel MSB_FIRST and read/write follows read_write_e (WRITE=0, READ=1), both from i2c_globals_pkg.

Parameters:
SLAVE_ADDRESS, 7'h68 (SLAVE0_ADDRESS), 7-bit address this target answers to
DATA_WIDTH, 8, byte width (must be 8)
REG_DEPTH, 4, registers in the file; power of two, 2..256
PTR_WIDTH, $clog2(REG_DEPTH), register pointer width

Ports:
pclk  input  1  system clock; must be >= 8x SCL frequency
areset_n  input  1  asynchronous active-low reset
scl_i  input  1  bus SCL (asynchronous to pclk)
sda_i  input  1  bus SDA (asynchronous to pclk)
sda_oe  output  1  1 = pull SDA low; 0 = release
host_addr  input  PTR_WIDTH  side-band register read address
host_rdata  output  DATA_WIDTH  reg[host_addr], combinational
wr_strobe  output  1  one-pclk pulse when a bus write updates a register
wr_addr  output  PTR_WIDTH  register written (valid with wr_strobe)
wr_data  output  DATA_WIDTH  byte written (valid with wr_strobe)
busy  output  1  high from an addressed START until STOP

Behaviour:
- Reset values: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, all registers=0, pointer=0, state=IDLE. Assertion mid-transfer releases SDA immediately (async).
- SCL and SDA each pass a 2-flop synchronizer followed by a history flop.
  - Edges: scl_rise, scl_fall.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Detection latency is 3 pclk from the pin edge.
- SDA is sampled on scl_rise. sda_oe changes only on scl_fall, one pclk after detection.
- Bit counter is 3 bits. A byte completes on the 8th scl_rise, assembled MSB first.
- States:
  - IDLE: waits for START, then goes to ADDR.
  - ADDR: shifts 8 bits.
    - Address match: go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL period; busy=1.
    - Mismatch: go to WAIT_STOP with no ACK.
  - After ADDR_ACK: WRITE goes to PTR; READ loads the shifter with reg[ptr] and goes to RD_DATA.
  - PTR: first write byte; ptr = byte mod REG_DEPTH; go to PTR_ACK (ACK driven), then WR_DATA.
  - WR_DATA: on the 8th bit, reg[ptr]=byte, wr_strobe pulses with wr_addr=ptr and wr_data=byte. Then WR_ACK (ACK driven), ptr=ptr+1 mod REG_DEPTH, back to WR_DATA.
  - RD_DATA: sda_oe = ~shifter MSB, updated on each scl_fall; 8 bits, then RD_ACK with SDA released.
  - RD_ACK: master ACK (0) sampled: ptr+1, reload, RD_DATA. Master NACK (1): WAIT_STOP with SDA released.
  - WAIT_STOP: ignores the bus until STOP or START.
- START in any state (repeated start) goes to ADDR; bit counter is cleared and ptr is kept.
- STOP in any state goes to IDLE; busy=0 and sda_oe=0. A partial byte is discarded with no write.
- Pointer wraps REG_DEPTH-1 -> 0 for both burst write and burst read.
- A STOP/START edge arriving in the same pclk as scl_rise cannot happen, because SCL is high during those edges. Bus-condition detection has priority.
- General-call address 0 is not supported (NACK).

Decomposition:
- i2c_globals_pkg additions:
  - typedef enum i2c_slave_state_e {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP}.
  - parameter ACK=1'b0, NACK=1'b1.
- Reused from i2c_globals_pkg: DATA_WIDTH, SLAVE*_ADDRESS, read_write_e.
- Sub-module i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det, stop_det, sda_s outputs.

Test Plan:
- Write 0xD0, 0x01, 0xA5, STOP -> three ACKs; wr_strobe once with wr_addr=1, wr_data=0xA5; host_rdata[1]=0xA5; busy 1->0.
- Write 0xD0, 0x01; repeated START; 0xD1; master NACK -> slave returns 0xA5 MSB first; SDA released after the NACK; STOP leads to IDLE.
- Address 0xD8 (7'h6C) -> no ACK, sda_oe stays 0, busy stays 0, registers unchanged.
- Write 0xD0, 0x03, 0x11, 0x22 -> reg[3]=0x11 and reg[0]=0x22 (wrap); read burst from ptr 3 with ACK, ACK, NACK -> 0x11, 0x22, reg[1].
- STOP after 4 bits of a data byte -> no wr_strobe, state IDLE; next transfer works.
- areset_n low while slave drives an ACK -> sda_oe=0 the same cycle; all registers 0 after release.

Source files
------------

// File: rtl/i2c_globals_pkg.sv
// Shared I2C constants and types for the bus models and the slave target.
// Bits travel MSB first; the R/W bit uses read_write_e.
package i2c_globals_pkg;

   localparam int         DATA_WIDTH     = 8;
   localparam logic [6:0] SLAVE0_ADDRESS = 7'h68;
   localparam logic [6:0] SLAVE1_ADDRESS = 7'h69;

   typedef enum logic {
      WRITE = 1'b0,
      READ  = 1'b1
   } read_write_e;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_slave_state_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with history flops; emits registered edge and bus-condition
// pulses three pclk after the pin edge, plus the SDA level aligned with them.
module i2c_bus_sync (
   input  logic pclk,
   input  logic areset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   // [0] metastable, [1] synchronized, [2] history; reset to the idle (high) bus level
   logic [2:0] scl_pipe;
   logic [2:0] sda_pipe;

   always_ff @(posedge pclk or negedge areset_n) begin
      if (!areset_n) begin
         scl_pipe  <= '1;
         sda_pipe  <= '1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_s     <= 1'b1;
      end else begin
         scl_pipe  <= {scl_pipe[1:0], scl_i};
         sda_pipe  <= {sda_pipe[1:0], sda_i};
         scl_rise  <= scl_pipe[1] & ~scl_pipe[2];
         scl_fall  <= ~scl_pipe[1] & scl_pipe[2];
         start_det <= scl_pipe[1] & scl_pipe[2] & ~sda_pipe[1] & sda_pipe[2];
         stop_det  <= scl_pipe[1] & scl_pipe[2] & sda_pipe[1] & ~sda_pipe[2];
         sda_s     <= sda_pipe[1];
      end
   end

endmodule

// File: rtl/i2c_slave_target.sv
// I2C slave endpoint: address/pointer/data decode, small register file, open-drain SDA.
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting address + R/W
//   ADDR_ACK  | acknowledging our address
//   PTR       | shifting register pointer byte
//   PTR_ACK   | acknowledging pointer
//   WR_DATA   | shifting a write byte
//   WR_ACK    | acknowledging write byte, pointer advances
//   RD_DATA   | driving read byte MSB first
//   RD_ACK    | sampling master ACK/NACK
//   WAIT_STOP | not addressed or done, ignoring bus until START/STOP
module i2c_slave_target #(
   parameter logic [6:0] SLAVE_ADDRESS = i2c_globals_pkg::SLAVE0_ADDRESS,
   parameter int         DATA_WIDTH    = i2c_globals_pkg::DATA_WIDTH,
   parameter int         REG_DEPTH     = 4,
   parameter int         PTR_WIDTH     = $clog2(REG_DEPTH)
) (
   input  logic                  pclk,
   input  logic                  areset_n,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   input  logic [PTR_WIDTH-1:0]  host_addr,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  wr_strobe,
   output logic [PTR_WIDTH-1:0]  wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy
);

   import i2c_globals_pkg::*;

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_bus_sync (
      .pclk      (pclk),
      .areset_n  (areset_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_slave_state_e      state, state_nxt;
   logic [2:0]            bit_cnt, bit_cnt_nxt;
   logic [DATA_WIDTH-1:0] shifter, shifter_nxt, rx_byte;
   logic [PTR_WIDTH-1:0]  ptr, ptr_nxt, ptr_inc;
   read_write_e           rw, rw_nxt;
   logic                  sda_oe_nxt, busy_nxt, wr_en;
   logic [DATA_WIDTH-1:0] regs [REG_DEPTH];

   assign rx_byte    = {shifter[DATA_WIDTH-2:0], sda_s};
   assign ptr_inc    = ptr + PTR_WIDTH'(1);
   assign host_rdata = regs[host_addr];

   always_ff @(posedge pclk or negedge areset_n) begin
      if (!areset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shifter <= '0;
         ptr     <= '0;
         rw      <= WRITE;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shifter <= shifter_nxt;
         ptr     <= ptr_nxt;
         rw      <= rw_nxt;
         sda_oe  <= sda_oe_nxt;
         busy    <= busy_nxt;
      end
   end

   // bit_cnt counts down from 7; terminal count 0 on a rise completes the byte
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shifter_nxt = shifter;
      ptr_nxt     = ptr;
      rw_nxt      = rw;
      sda_oe_nxt  = sda_oe;
      busy_nxt    = busy;
      wr_en       = 1'b0;
      if (stop_det) begin
         state_nxt  = IDLE;
         busy_nxt   = 1'b0;
         sda_oe_nxt = 1'b0;
      end else if (start_det) begin
         state_nxt   = ADDR;
         bit_cnt_nxt = 3'd7;
         sda_oe_nxt  = 1'b0;
      end else if (scl_fall) begin
         case (state)
            ADDR_ACK, PTR_ACK, WR_ACK: sda_oe_nxt = 1'b1;
            RD_DATA:                   sda_oe_nxt = ~shifter[DATA_WIDTH-1];
            default:                   sda_oe_nxt = 1'b0;
         endcase
      end else if (scl_rise) begin
         case (state)
            ADDR: begin
               shifter_nxt = rx_byte;
               bit_cnt_nxt = bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  if (rx_byte[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                     state_nxt = ADDR_ACK;
                     busy_nxt  = 1'b1;
                     rw_nxt    = read_write_e'(rx_byte[0]);
                  end else begin
                     state_nxt = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               bit_cnt_nxt = 3'd7;
               if (rw == READ) begin
                  shifter_nxt = regs[ptr];
                  state_nxt   = RD_DATA;
               end else begin
                  state_nxt   = PTR;
               end
            end
            PTR: begin
               shifter_nxt = rx_byte;
               bit_cnt_nxt = bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  ptr_nxt   = rx_byte[PTR_WIDTH-1:0];
                  state_nxt = PTR_ACK;
               end
            end
            PTR_ACK: begin
               bit_cnt_nxt = 3'd7;
               state_nxt   = WR_DATA;
            end
            WR_DATA: begin
               shifter_nxt = rx_byte;
               bit_cnt_nxt = bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  wr_en     = 1'b1;
                  state_nxt = WR_ACK;
               end
            end
            WR_ACK: begin
               ptr_nxt     = ptr_inc;
               bit_cnt_nxt = 3'd7;
               state_nxt   = WR_DATA;
            end
            RD_DATA: begin
               shifter_nxt = {shifter[DATA_WIDTH-2:0], 1'b0};
               bit_cnt_nxt = bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) state_nxt = RD_ACK;
            end
            RD_ACK: begin
               if (sda_s == ACK) begin
                  ptr_nxt     = ptr_inc;
                  shifter_nxt = regs[ptr_inc];
                  bit_cnt_nxt = 3'd7;
                  state_nxt   = RD_DATA;
               end else begin
                  state_nxt   = WAIT_STOP;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         wr_strobe <= wr_en;
         if (wr_en) begin
            regs[ptr] <= rx_byte;
            wr_addr   <= ptr;
            wr_data   <= rx_byte;
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-level I2C master drives the bus, a
// transaction-level register/pointer model supplies every expected value.
module tb_i2c_slave_target;

   localparam int Q = 8;  // pclk per quarter SCL period

   logic       pclk = 1'b0;
   logic       areset_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic [1:0] host_addr = '0;
   logic       sda_oe, wr_strobe, busy;
   logic [7:0] host_rdata, wr_data;
   logic [1:0] wr_addr;

   assign sda_bus = sda_m & ~sda_oe;

   always #5 pclk = ~pclk;

   i2c_slave_target dut (
      .pclk       (pclk),
      .areset_n   (areset_n),
      .scl_i      (scl),
      .sda_i      (sda_bus),
      .sda_oe     (sda_oe),
      .host_addr  (host_addr),
      .host_rdata (host_rdata),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   int         total = 0;
   int         bad = 0;
   int         stb_cnt = 0;
   int         oe_cnt = 0;
   logic [1:0] stb_addr = '0;
   logic [7:0] stb_data = '0;

   always @(negedge pclk) begin
      if (wr_strobe) begin
         stb_cnt  <= stb_cnt + 1;
         stb_addr <= wr_addr;
         stb_data <= wr_data;
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   // reference model: register array and pointer, mod-4 arithmetic
   logic [7:0] m_regs [4];
   int         m_ptr;
   logic [7:0] wbuf [4];

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic peek(input logic [1:0] a, output logic [7:0] d);
      host_addr = a;
      #1;
      d = host_rdata;
   endtask

   task automatic check_regs(input string nm);
      logic [7:0] d;
      for (int a = 0; a < 4; a++) begin
         peek(2'(a), d);
         chk(nm, 32'(d), 32'(m_regs[a]));
      end
   endtask

   task automatic do_start();
      sda_m = 1'b1; tick(Q);
      scl   = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl   = 1'b0; tick(Q);
   endtask

   task automatic do_stop();
      sda_m = 1'b0; tick(Q);
      scl   = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      sda_m = b; tick(Q);
      scl   = 1'b1; tick(Q);
      s     = sda_bus;
      scl   = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic master_nack, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bus_bit(1'b1, s);
         d = {d[6:0], s};
      end
      bus_bit(master_nack, s);
   endtask

   task automatic do_write(input logic [7:0] p, input int n);
      logic ack;
      int   s0, last_addr;
      s0 = stb_cnt;
      last_addr = 0;
      do_start();
      write_byte(8'hD0, ack); chk("w_addr_ack", 32'(ack), 1);
      write_byte(p, ack);     chk("w_ptr_ack", 32'(ack), 1);
      m_ptr = int'(p) % 4;
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], ack); chk("w_data_ack", 32'(ack), 1);
         m_regs[m_ptr] = wbuf[i];
         last_addr = m_ptr;
         m_ptr = (m_ptr + 1) % 4;
      end
      chk("w_busy", 32'(busy), 1);
      do_stop(); tick(4);
      chk("w_busy_end", 32'(busy), 0);
      chk("w_strobes", 32'(stb_cnt - s0), 32'(n));
      if (n > 0) begin
         chk("w_strobe_addr", 32'(stb_addr), 32'(last_addr));
         chk("w_strobe_data", 32'(stb_data), 32'(wbuf[n-1]));
      end
   endtask

   task automatic do_read(input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      do_start();
      write_byte(8'hD0, ack); chk("r_addr_ack", 32'(ack), 1);
      write_byte(p, ack);     chk("r_ptr_ack", 32'(ack), 1);
      m_ptr = int'(p) % 4;
      do_start();
      write_byte(8'hD1, ack); chk("r_raddr_ack", 32'(ack), 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         chk("r_data", 32'(d), 32'(m_regs[m_ptr]));
         if (i != n - 1) m_ptr = (m_ptr + 1) % 4;
      end
      chk("r_released", 32'(sda_oe), 0);
      chk("r_busy", 32'(busy), 1);
      do_stop(); tick(4);
      chk("r_busy_end", 32'(busy), 0);
   endtask

   typedef struct {
      logic [7:0] addr_b;
      logic [7:0] ptr_b;
      logic [7:0] data;
      logic       exp_ack;
      logic [1:0] exp_addr;
      logic [7:0] exp_val;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic       ack;
      logic [7:0] d;
      int         s0, o0;

      vecs[0] = '{8'hD0, 8'h01, 8'hA5, 1'b1, 2'd1, 8'hA5};
      vecs[1] = '{8'hD0, 8'h02, 8'h3C, 1'b1, 2'd2, 8'h3C};
      vecs[2] = '{8'hD8, 8'h00, 8'hFF, 1'b0, 2'd0, 8'h00};
      vecs[3] = '{8'hD0, 8'h07, 8'h5A, 1'b1, 2'd3, 8'h5A};
      vecs[4] = '{8'h00, 8'h01, 8'hEE, 1'b0, 2'd1, 8'hA5};
      vecs[5] = '{8'hD2, 8'h02, 8'h99, 1'b0, 2'd2, 8'h3C};
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_ptr = 0;

      tick(3);
      chk("rst_sda_oe", 32'(sda_oe), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_strobe", 32'(wr_strobe), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      check_regs("rst_regs");
      areset_n = 1'b1;
      tick(4);

      // table: single-byte writes and addresses that must not be acknowledged
      for (int i = 0; i < 6; i++) begin
         s0 = stb_cnt;
         o0 = oe_cnt;
         do_start();
         write_byte(vecs[i].addr_b, ack);
         chk("vec_addr_ack", 32'(ack), 32'(vecs[i].exp_ack));
         if (vecs[i].exp_ack) begin
            write_byte(vecs[i].ptr_b, ack); chk("vec_ptr_ack", 32'(ack), 1);
            write_byte(vecs[i].data, ack);  chk("vec_data_ack", 32'(ack), 1);
            chk("vec_busy", 32'(busy), 1);
            m_regs[int'(vecs[i].ptr_b) % 4] = vecs[i].data;
            m_ptr = (int'(vecs[i].ptr_b) + 1) % 4;
         end else begin
            chk("vec_nack_oe", 32'(oe_cnt - o0), 0);
            chk("vec_nack_busy", 32'(busy), 0);
         end
         do_stop(); tick(4);
         chk("vec_busy_end", 32'(busy), 0);
         chk("vec_strobes", 32'(stb_cnt - s0), 32'(vecs[i].exp_ack));
         if (vecs[i].exp_ack) begin
            chk("vec_wr_addr", 32'(stb_addr), 32'(vecs[i].exp_addr));
            chk("vec_wr_data", 32'(stb_data), 32'(vecs[i].data));
         end
         peek(vecs[i].exp_addr, d);
         chk("vec_host", 32'(d), 32'(vecs[i].exp_val));
      end

      // pointer set, repeated START, single read with NACK
      do_read(8'h01, 1);
      chk("a_sda_oe_idle", 32'(sda_oe), 0);

      // burst write across the wrap, then burst read across it
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(8'h03, 2);
      peek(2'd3, d); chk("wrap_reg3", 32'(d), 32'h11);
      peek(2'd0, d); chk("wrap_reg0", 32'(d), 32'h22);
      do_read(8'h03, 3);

      // STOP in the middle of a data byte
      s0 = stb_cnt;
      do_start();
      write_byte(8'hD0, ack); chk("part_addr_ack", 32'(ack), 1);
      write_byte(8'h01, ack); chk("part_ptr_ack", 32'(ack), 1);
      m_ptr = 1;
      for (int i = 0; i < 4; i++) bus_bit(1'(i % 2 == 0), ack);
      do_stop(); tick(4);
      chk("part_strobes", 32'(stb_cnt - s0), 0);
      chk("part_busy", 32'(busy), 0);
      check_regs("part_regs");
      wbuf[0] = 8'h66;
      do_write(8'h01, 1);
      check_regs("part_next");

      // randomized transactions against the model
      for (int t = 0; t < 20; t++) begin
         int kind, n;
         logic [6:0] a7;
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 3);
         if (kind == 0) begin
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(8'($urandom), n);
         end else if (kind == 1) begin
            do_read(8'($urandom), n);
         end else begin
            a7 = 7'($urandom);
            if (a7 == 7'h68) a7 = 7'h10;
            o0 = oe_cnt;
            do_start();
            write_byte({a7, 1'($urandom)}, ack);
            chk("rnd_nack", 32'(ack), 0);
            chk("rnd_nack_oe", 32'(oe_cnt - o0), 0);
            do_stop(); tick(4);
            chk("rnd_nack_busy", 32'(busy), 0);
         end
         check_regs("rnd_regs");
      end

      // reset while the slave holds an address ACK
      do_start();
      for (int i = 7; i >= 0; i--) bus_bit(1'(8'hD0 >> i), ack);
      for (int k = 0; k < 40 && !sda_oe; k++) tick(1);
      chk("rst_ack_driven", 32'(sda_oe), 1);
      #2 areset_n = 1'b0;
      #1;
      chk("rst_async_oe", 32'(sda_oe), 0);
      chk("rst_async_busy", 32'(busy), 0);
      scl = 1'b1; sda_m = 1'b1;
      tick(4);
      areset_n = 1'b1;
      tick(4);
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_ptr = 0;
      check_regs("rst_regs_after");
      chk("rst_wr_addr_after", 32'(wr_addr), 0);
      chk("rst_wr_data_after", 32'(wr_data), 0);
      wbuf[0] = 8'h5C;
      do_write(8'h02, 1);
      check_regs("rst_recover");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
